// File: rtl/pspin_cfg_pkg.sv
// ============================================================================
//  Module   : pspin_cfg_pkg
//  Purpose  : Shared cluster configuration and command/response types.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pspin_cfg_pkg;

    localparam int unsigned NUM_CORES          = 8;
    localparam int unsigned NUM_CMD_INTERFACES = 3;
    localparam int unsigned NUM_HPU_CMDS       = 4;
    localparam int unsigned CORE_ID_W          = $clog2(NUM_CORES);

    // Two bits so that out-of-range interface ids can be expressed and flagged.
    typedef logic [1:0] pspin_cmd_intf_id_t;

    typedef struct packed {
        logic [CORE_ID_W-1:0] core_id;
        logic [1:0]           local_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t      cmd_id;
        pspin_cmd_intf_id_t intf_id;
        logic [31:0]        descr;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [7:0]    status;
    } pspin_cmd_resp_t;

endpackage

`default_nettype wire

// File: rtl/pspin_cmd_rr_arb.sv
// ============================================================================
//  Module   : pspin_cmd_rr_arb
//  Purpose  : Round-robin arbiter with pointer register, request mask and
//             grant-enable; the pointer moves past the winner on each grant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pspin_cmd_rr_arb #(
    parameter  int unsigned NUM_REQ = 8,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    localparam int unsigned CW = IDX_W + 1;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] elig;
    logic [CW-1:0]      cand;

    assign elig = req_i & mask_i;

    // Scan from the pointer upward with wrap; first eligible requester wins.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (en_i && !gnt_valid_o && elig[cand[IDX_W-1:0]]) begin
                gnt_valid_o                = 1'b1;
                gnt_idx_o                  = cand[IDX_W-1:0];
                gnt_o[cand[IDX_W-1:0]]     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

`default_nettype wire

// File: rtl/pspin_cmd_arbiter.sv
// ============================================================================
//  Module   : pspin_cmd_arbiter
//  Purpose  : Per-cluster HPU command arbiter: round-robin issue, interface
//             steering, shared completion return, per-core inflight counters.
//             Define PSPIN_CMD_ARB_CREDIT_EN to mask cores at MAX_INFLIGHT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pspin_cmd_arbiter
    import pspin_cfg_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = NUM_CORES,
    parameter  int unsigned NUM_INTF     = NUM_CMD_INTERFACES,
    parameter  int unsigned MAX_INFLIGHT = NUM_HPU_CMDS,
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1),
    localparam int unsigned REQ_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic            [NUM_REQ-1:0]       req_valid_i,
    output logic            [NUM_REQ-1:0]       req_ready_o,
    input  pspin_cmd_req_t  [NUM_REQ-1:0]       req_i,
    output logic            [NUM_INTF-1:0]      intf_valid_o,
    input  logic            [NUM_INTF-1:0]      intf_ready_i,
    output pspin_cmd_req_t                      intf_req_o,
    input  logic            [NUM_INTF-1:0]      resp_valid_i,
    output logic            [NUM_INTF-1:0]      resp_ready_o,
    input  pspin_cmd_resp_t [NUM_INTF-1:0]      resp_i,
    output logic                                cmpl_valid_o,
    input  logic                                cmpl_ready_i,
    output pspin_cmd_resp_t                     cmpl_o,
    output logic            [NUM_REQ-1:0][CNT_W-1:0] inflight_o,
    output logic                                err_o
);

    typedef logic [CNT_W-1:0] inflight_cnt_t;

    logic [NUM_INTF-1:0]          intf_valid_q, intf_valid_d;
    pspin_cmd_req_t               intf_req_q, intf_req_d;
    logic                         cmpl_valid_q, cmpl_valid_d;
    pspin_cmd_resp_t              cmpl_q, cmpl_d;
    inflight_cnt_t [NUM_REQ-1:0]  cnt_q, cnt_d;
    logic                         err_q, err_d;

    logic                  buf_free, cmpl_free;
    logic [NUM_REQ-1:0]    credit_mask;
    logic [REQ_IDX_W-1:0]  gnt_idx;
    logic                  gnt_valid, intf_id_ok, issue_ok;
    pspin_cmd_req_t        sel_req;
    logic                  resp_acc, cnt_err;
    pspin_cmd_resp_t       resp_sel;

    // Buffer frees up in the same cycle it drains, giving back-to-back issue.
    assign buf_free = ~(|intf_valid_q) | (|(intf_valid_q & intf_ready_i));

`ifdef PSPIN_CMD_ARB_CREDIT_EN
    always_comb begin
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            credit_mask[c] = (cnt_q[c] != CNT_W'(MAX_INFLIGHT));
        end
    end
`else
    assign credit_mask = '1;
`endif

    pspin_cmd_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_valid_i),
        .mask_i      (credit_mask),
        .en_i        (buf_free),
        .gnt_o       (req_ready_o),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign sel_req    = req_i[gnt_idx];
    assign intf_id_ok = (32'(sel_req.intf_id) < NUM_INTF);
    assign issue_ok   = gnt_valid & intf_id_ok;

    always_comb begin
        intf_valid_d = intf_valid_q;
        intf_req_d   = intf_req_q;
        if (|(intf_valid_q & intf_ready_i)) intf_valid_d = '0;
        if (issue_ok) begin
            intf_req_d = sel_req;
            for (int unsigned i = 0; i < NUM_INTF; i++) begin
                intf_valid_d[i] = (32'(sel_req.intf_id) == i);
            end
        end
    end

    // Lowest-index completion wins whenever the output register can take it.
    assign cmpl_free = ~cmpl_valid_q | cmpl_ready_i;

    always_comb begin
        resp_ready_o = '0;
        resp_acc     = 1'b0;
        resp_sel     = '0;
        for (int unsigned i = 0; i < NUM_INTF; i++) begin
            if (cmpl_free && resp_valid_i[i] && !resp_acc) begin
                resp_ready_o[i] = 1'b1;
                resp_acc        = 1'b1;
                resp_sel        = resp_i[i];
            end
        end
        cmpl_valid_d = resp_acc ? 1'b1 : (cmpl_valid_q & ~cmpl_ready_i);
        cmpl_d       = resp_acc ? resp_sel : cmpl_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        cnt_err = 1'b0;
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (issue_ok && (32'(sel_req.cmd_id.core_id) == c) &&
                !(resp_acc && (32'(resp_sel.cmd_id.core_id) == c))) begin
                if (cnt_q[c] == CNT_W'(MAX_INFLIGHT)) cnt_err  = 1'b1;
                else                                  cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end else if (resp_acc && (32'(resp_sel.cmd_id.core_id) == c) &&
                         !(issue_ok && (32'(sel_req.cmd_id.core_id) == c))) begin
                if (cnt_q[c] == '0) cnt_err  = 1'b1;
                else                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
        end
    end

    assign err_d = (gnt_valid & ~intf_id_ok) | cnt_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intf_valid_q <= '0;
            intf_req_q   <= '0;
            cmpl_valid_q <= 1'b0;
            cmpl_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            intf_valid_q <= intf_valid_d;
            intf_req_q   <= intf_req_d;
            cmpl_valid_q <= cmpl_valid_d;
            cmpl_q       <= cmpl_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign intf_valid_o = intf_valid_q;
    assign intf_req_o   = intf_req_q;
    assign cmpl_valid_o = cmpl_valid_q;
    assign cmpl_o       = cmpl_q;
    assign inflight_o   = cnt_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire
